// File: rtl/arm_dmem_hs.sv
// Data memory for the ARM core with byte/halfword/word access, load sign extension
// and a fixed-latency req/ready -> rvalid handshake with error responses.
module arm_dmem_hs #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept, enter_resp;

    logic [31:0] addr_q, wdata_q;
    logic        we_q, signext_q;
    logic [1:0]  size_q;

    logic [31:0] op_addr, op_wdata;
    logic        op_we, op_signext, op_err;
    logic [1:0]  op_size;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH];
    logic [31:0] word_rd, wd, load_val;
    logic [3:0]  be;
    logic [7:0]  lb;
    logic [15:0] lh;

    assign ready  = (state == IDLE);
    assign accept = req && ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // With LATENCY=1 the access happens on the accept edge, before the capture registers load.
    assign op_addr    = (state == IDLE) ? addr    : addr_q;
    assign op_wdata   = (state == IDLE) ? wdata   : wdata_q;
    assign op_we      = (state == IDLE) ? we      : we_q;
    assign op_size    = (state == IDLE) ? size    : size_q;
    assign op_signext = (state == IDLE) ? signext : signext_q;
    assign idx        = op_addr[AW+1:2];

    always_comb begin
        op_err = 1'b0;
        case (op_size)
            2'b00:   op_err = 1'b0;
            2'b01:   op_err = op_addr[0];
            2'b10:   op_err = |op_addr[1:0];
            default: op_err = 1'b1;
        endcase
        if ({2'b00, op_addr[31:2]} >= 32'(DEPTH)) op_err = 1'b1;
    end

    always_comb begin
        be = 4'b0000;
        wd = 32'h0;
        case (op_size)
            2'b00: begin
                be = 4'b0001 << op_addr[1:0];
                wd = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be = op_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{op_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = op_wdata;
            end
        endcase
    end

    always_comb begin
        word_rd = mem[idx];
        case (op_addr[1:0])
            2'd0:    lb = word_rd[7:0];
            2'd1:    lb = word_rd[15:8];
            2'd2:    lb = word_rd[23:16];
            default: lb = word_rd[31:24];
        endcase
        lh = op_addr[1] ? word_rd[31:16] : word_rd[15:0];
        case (op_size)
            2'b00:   load_val = {{24{op_signext & lb[7]}}, lb};
            2'b01:   load_val = {{16{op_signext & lh[15]}}, lh};
            default: load_val = word_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            rvalid <= enter_resp;
            err    <= enter_resp && op_err;
            rdata  <= (enter_resp && !op_err && !op_we) ? load_val : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q    <= addr;
            wdata_q   <= wdata;
            we_q      <= we;
            size_q    <= size;
            signext_q <= signext;
        end
    end

    // Storage is never cleared; a reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_arm_dmem_hs.sv
// Bench for arm_dmem_hs: directed vector table, hand-written handshake/reset sequences,
// and randomized traffic compared against a byte-array model of the memory.
module tb_arm_dmem_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req1 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;
    logic        ready1, rvalid1, err1;
    logic [31:0] rdata1;

    int total = 0;
    int bad   = 0;

    bit [7:0] mem_b [256];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        se;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    arm_dmem_hs #(.DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .signext(signext), .addr(addr), .wdata(wdata),
        .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    arm_dmem_hs #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we), .size(size),
        .signext(signext), .addr(addr), .wdata(wdata),
        .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory model: little-endian byte array, sign extension by arithmetic.
    function automatic void modelAccess(input logic w, input logic [1:0] sz, input logic se,
                                        input logic [31:0] a, input logic [31:0] d,
                                        output logic [31:0] rd, output logic e);
        int n;
        longint unsigned val;
        n  = 1 << sz;
        e  = (sz == 2'd3) || ((a % n) != 0) || ((a / 4) >= 64);
        rd = 32'h0;
        if (!e) begin
            if (w) begin
                for (int k = 0; k < n; k++) mem_b[int'(a) + k] = d[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < n; k++) val = val + (longint'(mem_b[int'(a) + k]) << (8 * k));
                if (se && n < 4 && (((val >> (8 * n - 1)) & 1) == 1))
                    val = val - (64'd1 << (8 * n));
                rd = val[31:0];
            end
        end
    endfunction

    task automatic applyStimulus(input bit which, input logic w, input logic [1:0] sz,
                                 input logic se, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic e, output int lat);
        int guard;
        bit got;
        @(negedge clk);
        we = w; size = sz; signext = se; addr = a; wdata = d;
        if (which) req1 = 1'b1; else req = 1'b1;
        guard = 0;
        while (!(which ? ready1 : ready) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        req1 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (which ? rvalid1 : rvalid) got = 1'b1;
        end
        rd = which ? rdata1 : rdata;
        e  = which ? err1 : err;
        @(negedge clk);
        checkOutput("pulse_end", {30'b0, (which ? rvalid1 : rvalid), (which ? ready1 : ready)}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        e, exp_e;
        int          lat;
        logic [5:0]  rdy_v, vld_v;
        logic [31:0] b2b_rd;
        logic        seen;
        logic [1:0]  sz;
        int          r;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11223344, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'hFFFFFFAB, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11AB3344, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h12,  32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h12,  32'h0,        32'h000000AB, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h22,  32'h12348001, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h21,  32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h80010008, 1'b0};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'h5A000000, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h11AB3344, 1'b0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h13,  32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'h000011AB, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h00000033, 1'b0};
        vecs[17] = '{1'b1, 2'd1, 1'b0, 32'h21,  32'h0000FFFF, 32'h00000000, 1'b1};
        vecs[18] = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h80010008, 1'b0};
        vecs[19] = '{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h5A00003F, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hold_ready", {31'b0, ready}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready",  {31'b0, ready},  32'h1);
        checkOutput("reset_rvalid", {31'b0, rvalid}, 32'h0);
        checkOutput("reset_err",    {31'b0, err},    32'h0);
        checkOutput("reset_rdata",  rdata,           32'h0);
        checkOutput("reset_ready1", {31'b0, ready1}, 32'h1);

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h5A000000 + 32'(i), rd, e, lat);
            modelAccess(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h5A000000 + 32'(i), exp_rd, exp_e);
        end

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, vecs[i].w, vecs[i].sz, vecs[i].se, vecs[i].a, vecs[i].d, rd, e, lat);
            modelAccess(vecs[i].w, vecs[i].sz, vecs[i].se, vecs[i].a, vecs[i].d, exp_rd, exp_e);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Two loads with req held high: second accept waits until after the first rvalid.
        @(negedge clk);
        we = 1'b0; size = 2'd2; signext = 1'b0; addr = 32'h10; req = 1'b1;
        rdy_v = '0; vld_v = '0; b2b_rd = 32'h0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            rdy_v[c] = ready;
            vld_v[c] = rvalid;
            if (c == 5) begin
                b2b_rd = rdata;
                req = 1'b0;
            end
        end
        checkOutput("b2b_ready_pattern",  {26'b0, rdy_v}, 32'b001001);
        checkOutput("b2b_rvalid_pattern", {26'b0, vld_v}, 32'b100100);
        checkOutput("b2b_rdata", b2b_rd, 32'h11AB3344);
        @(negedge clk);

        // Reset while a store waits: store must be dropped without a response.
        @(negedge clk);
        we = 1'b1; size = 2'd2; signext = 1'b0; addr = 32'h30; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_wait", {31'b0, ready}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_ready",  {31'b0, ready},  32'h1);
        checkOutput("abort_rvalid", {31'b0, rvalid}, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rvalid) seen = 1'b1;
        end
        checkOutput("abort_no_rvalid", {31'b0, seen}, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, e, lat);
        checkOutput("abort_mem_kept", rd, 32'h5A00000C);

        // LATENCY=1 instance: response one cycle after acceptance.
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, rd, e, lat);
        checkOutput("l1_store_latency", 32'(lat), 32'd1);
        checkOutput("l1_store_err", {31'b0, e}, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, e, lat);
        checkOutput("l1_load_latency", 32'(lat), 32'd1);
        checkOutput("l1_load_rdata", rd, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 32'h3, 32'h0, rd, e, lat);
        checkOutput("l1_byte_rdata", rd, 32'h00000012);

        // Random traffic against the byte-array model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 255));
            applyStimulus(1'b0, 1'($urandom), sz, 1'($urandom), a, $urandom, rd, e, lat);
            modelAccess(we, sz, signext, a, wdata, exp_rd, exp_e);
            checkOutput($sformatf("rand%0d_rdata", i), rd, exp_rd);
            checkOutput($sformatf("rand%0d_err", i), {31'b0, e}, {31'b0, exp_e});
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
